axi_wr_arbiter_2m: RTL and testbench

Sequencing controller that shares one slave-side AXI write path between two masters. It arbitrates AW requests round-robin and drives the select line of the write-channel 2:1 datapath muxes (AW, W and B payload). It holds the grant for one complete transaction: address, all data beats, then the response. It gates every VALID/READY handshake so that only the granted master sees the slave.

---
 rtl/axi_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 21 ++
 rtl/axi_wr_arbiter_2m.sv | 152 +++++++++++++++
 tb/tb_axi_wr_arbiter_2m.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI write/read arbiters.
// Pure declarations: no logic, no latency, no flow control.
package axi_arb_pkg;

   localparam int LEN_W_DEFAULT = 8;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin picker; zero latency, no backpressure of its own.
// With both requesting, the master that did not win last time is chosen.
module rr_arb2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      // Contention (or no request) alternates away from the previous winner.
      grant = ~last_grant;
      if (req == 2'b01) begin
         grant = M0;
      end else if (req == 2'b10) begin
         grant = M1;
      end
   end

endmodule

// File: rtl/axi_wr_arbiter_2m.sv
// Shares one slave AXI write path between two masters, one whole transaction (AW, W beats, B) per grant.
// Grant registered one cycle after AWVALID; gated handshakes are combinational, any stall holds the state.
module axi_wr_arbiter_2m
   import axi_arb_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEFAULT
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             M0_AWVALID,
   input  logic             M1_AWVALID,
   input  logic [LEN_W-1:0] M0_AWLEN,
   input  logic [LEN_W-1:0] M1_AWLEN,
   output logic             M0_AWREADY,
   output logic             M1_AWREADY,
   output logic             S_AWVALID,
   input  logic             S_AWREADY,
   input  logic             M0_WVALID,
   input  logic             M1_WVALID,
   input  logic             M0_WLAST,
   input  logic             M1_WLAST,
   output logic             M0_WREADY,
   output logic             M1_WREADY,
   output logic             S_WVALID,
   input  logic             S_WREADY,
   input  logic             S_BVALID,
   output logic             S_BREADY,
   output logic             M0_BVALID,
   output logic             M1_BVALID,
   input  logic             M0_BREADY,
   input  logic             M1_BREADY,
   output logic             sel,
   output logic             busy,
   output logic             len_err
);

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             last_grant_q, last_grant_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             len_err_q, len_err_d;
   logic             grant;

   logic             aw_vld;
   logic [LEN_W-1:0] aw_len;
   logic             w_vld;
   logic             w_last;
   logic             b_rdy;
   logic             is_m0;
   logic             is_m1;

   rr_arb2 u_rr_arb2 (
      .req        ({M1_AWVALID, M0_AWVALID}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign is_m0  = (sel_q == M0);
   assign is_m1  = (sel_q == M1);
   assign aw_vld = is_m1 ? M1_AWVALID : M0_AWVALID;
   assign aw_len = is_m1 ? M1_AWLEN   : M0_AWLEN;
   assign w_vld  = is_m1 ? M1_WVALID  : M0_WVALID;
   assign w_last = is_m1 ? M1_WLAST   : M0_WLAST;
   assign b_rdy  = is_m1 ? M1_BREADY  : M0_BREADY;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      len_err_d    = len_err_q;
      M0_AWREADY   = 1'b0;
      M1_AWREADY   = 1'b0;
      S_AWVALID    = 1'b0;
      M0_WREADY    = 1'b0;
      M1_WREADY    = 1'b0;
      S_WVALID     = 1'b0;
      S_BREADY     = 1'b0;
      M0_BVALID    = 1'b0;
      M1_BVALID    = 1'b0;

      case (state_q)
         IDLE: begin
            if (M0_AWVALID || M1_AWVALID) begin
               sel_d   = grant;
               state_d = ADDR;
            end
         end
         ADDR: begin
            S_AWVALID  = aw_vld;
            M0_AWREADY = S_AWREADY & is_m0;
            M1_AWREADY = S_AWREADY & is_m1;
            if (aw_vld && S_AWREADY) begin
               beat_cnt_d = aw_len;
               state_d    = DATA;
            end
         end
         DATA: begin
            S_WVALID  = w_vld;
            M0_WREADY = S_WREADY & is_m0;
            M1_WREADY = S_WREADY & is_m1;
            if (w_vld && S_WREADY) begin
               // The counter only flags length errors; WLAST alone ends the burst.
               if (w_last) begin
                  if (beat_cnt_q != '0) begin
                     len_err_d = 1'b1;
                  end
                  state_d = RESP;
               end else if (beat_cnt_q == '0) begin
                  len_err_d = 1'b1;
               end
               if (beat_cnt_q != '0) begin
                  beat_cnt_d = beat_cnt_q - LEN_W'(1);
               end
            end
         end
         RESP: begin
            S_BREADY  = b_rdy;
            M0_BVALID = S_BVALID & is_m0;
            M1_BVALID = S_BVALID & is_m1;
            if (S_BVALID && b_rdy) begin
               last_grant_d = sel_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= IDLE;
         sel_q        <= M0;
         last_grant_q <= M1;
         beat_cnt_q   <= '0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         len_err_q    <= len_err_d;
      end
   end

   assign sel     = sel_q;
   assign busy    = (state_q != IDLE);
   assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter_2m.sv
// Randomized bench for axi_wr_arbiter_2m: master/slave agents, a grant-order reference model
// and a scoreboard monitor that checks every slave-side transaction as it completes.
module tb_axi_wr_arbiter_2m;

   localparam int LW = 8;

   typedef struct {
      int len;
      int beats;
   } mtx_t;

   typedef struct {
      int m;
      int len;
      int beats;
      bit err;
      bit timed;
   } exp_t;

   logic          ACLK;
   logic          ARESETN;
   logic [1:0]    m_awvalid, m_wvalid, m_wlast, m_bready;
   logic [LW-1:0] m_awlen [2];
   wire  [1:0]    m_awready, m_wready, m_bvalid;
   logic          S_AWREADY, S_WREADY, S_BVALID;
   wire           S_AWVALID, S_WVALID, S_BREADY, sel, busy, len_err;

   mtx_t tq0[$];
   mtx_t tq1[$];
   exp_t expq[$];

   int n_cmp;
   int n_fail;
   int model_last;
   bit model_err;
   int cyc;
   int req_cyc;
   bit mon_en;
   bit timed_phase;
   int slave_prob;
   int mwprob;

   axi_wr_arbiter_2m #(.LEN_W(LW)) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .M0_AWVALID (m_awvalid[0]),
      .M1_AWVALID (m_awvalid[1]),
      .M0_AWLEN   (m_awlen[0]),
      .M1_AWLEN   (m_awlen[1]),
      .M0_AWREADY (m_awready[0]),
      .M1_AWREADY (m_awready[1]),
      .S_AWVALID  (S_AWVALID),
      .S_AWREADY  (S_AWREADY),
      .M0_WVALID  (m_wvalid[0]),
      .M1_WVALID  (m_wvalid[1]),
      .M0_WLAST   (m_wlast[0]),
      .M1_WLAST   (m_wlast[1]),
      .M0_WREADY  (m_wready[0]),
      .M1_WREADY  (m_wready[1]),
      .S_WVALID   (S_WVALID),
      .S_WREADY   (S_WREADY),
      .S_BVALID   (S_BVALID),
      .S_BREADY   (S_BREADY),
      .M0_BVALID  (m_bvalid[0]),
      .M1_BVALID  (m_bvalid[1]),
      .M0_BREADY  (m_bready[0]),
      .M1_BREADY  (m_bready[1]),
      .sel        (sel),
      .busy       (busy),
      .len_err    (len_err)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit rnd(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   task automatic add_tx(input int m, input int len, input int beats);
      mtx_t t;
      t.len   = len;
      t.beats = beats;
      if (m == 0) tq0.push_back(t);
      else        tq1.push_back(t);
   endtask

   // Reference model: every queued transaction keeps its master requesting, so the
   // grant order is plain alternation while both have work, then whoever remains.
   task automatic model_phase(input bit timed);
      int   i0;
      int   i1;
      int   w;
      exp_t e;
      i0 = 0;
      i1 = 0;
      while (i0 < tq0.size() || i1 < tq1.size()) begin
         if (i0 < tq0.size() && i1 < tq1.size()) w = 1 - model_last;
         else if (i0 < tq0.size())                w = 0;
         else                                     w = 1;
         e.m = w;
         if (w == 0) begin
            e.len = tq0[i0].len; e.beats = tq0[i0].beats; i0++;
         end else begin
            e.len = tq1[i1].len; e.beats = tq1[i1].beats; i1++;
         end
         model_err  = model_err | (e.beats != e.len + 1);
         e.err      = model_err;
         e.timed    = timed;
         model_last = w;
         expq.push_back(e);
      end
   endtask

   task automatic wait_hs(input int m, input int ch, output bit ok);
      bit hit;
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge ACLK);
         case (ch)
            0:       hit = m_awvalid[m] && m_awready[m];
            1:       hit = m_wvalid[m] && m_wready[m];
            default: hit = m_bvalid[m] && m_bready[m];
         endcase
         @(posedge ACLK);
         #1;
         if (hit) begin
            ok = 1'b1;
            return;
         end
         if (ch == 1 && !m_wvalid[m]) m_wvalid[m] = rnd(mwprob);
         if (ch == 2) m_bready[m] = rnd(mwprob);
      end
      n_cmp++;
      n_fail++;
      $display("FAIL hs_timeout m%0d ch%0d: got no handshake, expected one within 3000 cycles", m, ch);
   endtask

   task automatic run_master(input int m);
      mtx_t t;
      int   n;
      bit   ok;
      n = (m == 0) ? tq0.size() : tq1.size();
      for (int k = 0; k < n; k++) begin
         t = (m == 0) ? tq0[k] : tq1[k];
         if (timed_phase) req_cyc = cyc;
         m_awvalid[m] = 1'b1;
         m_awlen[m]   = LW'(t.len);
         wait_hs(m, 0, ok);
         m_awvalid[m] = 1'b0;
         if (!ok) return;
         for (int b = 0; b < t.beats; b++) begin
            m_wlast[m]  = (b == t.beats - 1);
            m_wvalid[m] = rnd(mwprob);
            wait_hs(m, 1, ok);
            m_wvalid[m] = 1'b0;
            m_wlast[m]  = 1'b0;
            if (!ok) return;
         end
         m_bready[m] = rnd(mwprob);
         wait_hs(m, 2, ok);
         m_bready[m] = 1'b0;
         if (!ok) return;
      end
   endtask

   task automatic run_phase(input bit timed);
      timed_phase = timed;
      model_phase(timed);
      fork
         run_master(0);
         run_master(1);
      join
      repeat (4) @(posedge ACLK);
      #1;
      tq0.delete();
      tq1.delete();
      timed_phase = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(posedge ACLK);
      #1;
      ARESETN = 1'b0;
      @(posedge ACLK);
      #1;
      ARESETN    = 1'b1;
      model_last = 1;
      model_err  = 1'b0;
      expq.delete();
      @(negedge ACLK);
      chk("len_err_after_reset", len_err, 0);
      @(posedge ACLK);
      #1;
      mon_en = 1'b1;
   endtask

   // Slave agent: random ready, response raised some time after the WLAST beat.
   initial begin
      bit lhs;
      bit bhs;
      bit bpend;
      S_AWREADY = 1'b0;
      S_WREADY  = 1'b0;
      S_BVALID  = 1'b0;
      bpend     = 1'b0;
      forever begin
         @(negedge ACLK);
         lhs = |(m_wvalid & m_wready & m_wlast);
         bhs = S_BVALID && S_BREADY;
         if (!ARESETN) bpend = 1'b0;
         @(posedge ACLK);
         #1;
         if (!ARESETN) begin
            bpend    = 1'b0;
            S_BVALID = 1'b0;
         end else begin
            if (bhs) begin
               bpend    = 1'b0;
               S_BVALID = 1'b0;
            end
            if (lhs) bpend = 1'b1;
            S_BVALID = bpend && (S_BVALID || rnd(slave_prob));
         end
         S_AWREADY = rnd(slave_prob);
         S_WREADY  = rnd(slave_prob);
      end
   end

   // Monitor: follows each slave-side transaction and scores it on its B handshake.
   initial begin
      int   mst;
      bit   bubble;
      bit   gerr;
      int   beats;
      int   cm;
      int   om;
      exp_t cur;
      mst    = 0;
      bubble = 1'b0;
      gerr   = 1'b0;
      beats  = 0;
      cur    = '{m: 0, len: 0, beats: 0, err: 1'b0, timed: 1'b0};
      forever begin
         @(negedge ACLK);
         if (!mon_en || !ARESETN) begin
            mst    = 0;
            bubble = 1'b0;
            gerr   = 1'b0;
         end else begin
            if (bubble) begin
               chk("idle_bubble_busy_awvalid", {busy, S_AWVALID}, 0);
               bubble = 1'b0;
            end
            case (mst)
               0: begin
                  if (busy && expq.size() > 0) begin
                     cm = expq[0].m;
                     om = 1 - cm;
                     if (S_AWVALID !== m_awvalid[cm] || m_awready[cm] !== S_AWREADY ||
                         m_awready[om] !== 1'b0 || m_wready !== 2'b00 || m_bvalid !== 2'b00 ||
                         S_WVALID !== 1'b0 || S_BREADY !== 1'b0 || sel !== 1'(cm))
                        gerr = 1'b1;
                  end
                  if (S_AWVALID && S_AWREADY) begin
                     if (expq.size() == 0) begin
                        chk("unexpected_aw", 1, 0);
                     end else begin
                        cur = expq.pop_front();
                        chk("grant_sel", sel, cur.m);
                        beats = 0;
                        mst   = 1;
                     end
                  end
               end
               1: begin
                  cm = cur.m;
                  om = 1 - cm;
                  if (S_WVALID !== m_wvalid[cm] || m_wready[cm] !== S_WREADY ||
                      m_wready[om] !== 1'b0 || m_awready !== 2'b00 || m_bvalid !== 2'b00 ||
                      S_AWVALID !== 1'b0 || S_BREADY !== 1'b0 || sel !== 1'(cm) || busy !== 1'b1)
                     gerr = 1'b1;
                  if (S_WVALID && S_WREADY) begin
                     beats++;
                     if (m_wlast[cm]) mst = 2;
                  end
               end
               default: begin
                  cm = cur.m;
                  om = 1 - cm;
                  if (m_bvalid[cm] !== S_BVALID || S_BREADY !== m_bready[cm] ||
                      m_bvalid[om] !== 1'b0 || m_awready !== 2'b00 || m_wready !== 2'b00 ||
                      S_AWVALID !== 1'b0 || S_WVALID !== 1'b0 || sel !== 1'(cm) || busy !== 1'b1)
                     gerr = 1'b1;
                  if (S_BVALID && S_BREADY) begin
                     chk("beats_delivered", beats, cur.beats);
                     chk("len_err", len_err, cur.err);
                     chk("handshake_gating", gerr, 0);
                     if (cur.timed) chk("txn_cycles", cyc + 1 - req_cyc, 7);
                     gerr   = 1'b0;
                     mst    = 0;
                     bubble = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      bit ok;
      n_cmp       = 0;
      n_fail      = 0;
      model_last  = 1;
      model_err   = 1'b0;
      req_cyc     = 0;
      mon_en      = 1'b0;
      timed_phase = 1'b0;
      slave_prob  = 100;
      mwprob      = 100;
      ARESETN     = 1'b0;
      m_awvalid   = 2'b11;
      m_wvalid    = 2'b11;
      m_wlast     = 2'b00;
      m_bready    = 2'b11;
      m_awlen[0]  = '0;
      m_awlen[1]  = '0;

      // Reset: gated outputs stay low even with every master input asserted.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("reset_busy", busy, 0);
      chk("reset_sel", sel, 0);
      chk("reset_len_err", len_err, 0);
      chk("reset_s_awvalid", S_AWVALID, 0);
      chk("reset_m_awready", m_awready, 0);
      chk("reset_m_wready", m_wready, 0);
      chk("reset_s_wvalid", S_WVALID, 0);
      chk("reset_s_bready", S_BREADY, 0);
      chk("reset_m_bvalid", m_bvalid, 0);
      m_awvalid = 2'b00;
      m_wvalid  = 2'b00;
      m_bready  = 2'b00;
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;

      // Simultaneous requests from reset, three each: strict alternation from M0.
      slave_prob = 70;
      mwprob     = 70;
      for (int k = 0; k < 3; k++) begin
         int l;
         l = int'($urandom_range(7, 0));
         add_tx(0, l, l + 1);
         l = int'($urandom_range(7, 0));
         add_tx(1, l, l + 1);
      end
      run_phase(1'b0);

      // Single M0 burst with no wait states: 4 beats, back in IDLE 7 cycles after request.
      slave_prob = 100;
      mwprob     = 100;
      add_tx(0, 3, 4);
      run_phase(1'b1);

      // Heavy back-pressure on every channel.
      slave_prob = 25;
      mwprob     = 40;
      add_tx(0, 15, 16);
      add_tx(1, 9, 10);
      add_tx(0, 0, 1);
      run_phase(1'b0);

      // Random mixes of request counts, lengths and stall rates.
      for (int p = 0; p < 6; p++) begin
         int n0;
         int n1;
         n0 = int'($urandom_range(3, 0));
         n1 = int'($urandom_range(3, 0));
         for (int k = 0; k < n0; k++) begin
            int l;
            l = int'($urandom_range(7, 0));
            add_tx(0, l, l + 1);
         end
         for (int k = 0; k < n1; k++) begin
            int l;
            l = int'($urandom_range(7, 0));
            add_tx(1, l, l + 1);
         end
         slave_prob = int'($urandom_range(100, 30));
         mwprob     = int'($urandom_range(100, 30));
         run_phase(1'b0);
      end

      // Early WLAST: AWLEN=1 but only one beat.
      slave_prob = 100;
      mwprob     = 100;
      add_tx(0, 1, 1);
      run_phase(1'b0);
      do_reset();

      // Late WLAST: AWLEN=1 but three beats.
      slave_prob = 60;
      add_tx(1, 1, 3);
      run_phase(1'b0);
      do_reset();

      // Reset during DATA after two beats of an M1 burst.
      mon_en     = 1'b0;
      slave_prob = 100;
      mwprob     = 100;
      m_awvalid[1] = 1'b1;
      m_awlen[1]   = LW'(5);
      wait_hs(1, 0, ok);
      m_awvalid[1] = 1'b0;
      m_wlast[1]   = 1'b0;
      m_wvalid[1]  = 1'b1;
      wait_hs(1, 1, ok);
      wait_hs(1, 1, ok);
      @(negedge ACLK);
      chk("mid_pre_busy", busy, 1);
      chk("mid_pre_sel", sel, 1);
      chk("mid_pre_s_wvalid", S_WVALID, 1);
      #1;
      ARESETN = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_s_wvalid", S_WVALID, 0);
      chk("mid_rst_sel", sel, 0);
      chk("mid_rst_m1_wready", m_wready[1], 0);
      m_wvalid = 2'b00;
      @(posedge ACLK);
      #1;
      ARESETN    = 1'b1;
      model_last = 1;
      model_err  = 1'b0;
      expq.delete();
      @(posedge ACLK);
      #1;
      mon_en = 1'b1;

      // Normal arbitration resumes after the mid-transaction reset.
      slave_prob = 50;
      mwprob     = 60;
      for (int k = 0; k < 2; k++) begin
         int l;
         l = int'($urandom_range(5, 0));
         add_tx(0, l, l + 1);
         l = int'($urandom_range(5, 0));
         add_tx(1, l, l + 1);
      end
      run_phase(1'b0);

      chk("scoreboard_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
